// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared constants for the IF -> ID fetch queue.
//   FS_TO_DS_BUS_WD : width of one {pc, inst} entry passed from IF to ID.
//   FQ_DEPTH_DEF    : default number of queue entries.
//   is_pow2()       : elaboration-time helper for checking the DEPTH parameter.
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam int FS_TO_DS_BUS_WD = 64;
    localparam int FQ_DEPTH_DEF    = 4;

    // True when n is a power of two and at least 2.
    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage : fetch_queue_pkg

// File: rtl/fq_ram.sv
// -----------------------------------------------------------------------------
// fq_ram
// DEPTH x BUS_WD storage for the fetch queue: one synchronous write port and
// one asynchronous (combinational) read port.
// Ports:
//   clk   : write clock (rising edge)
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
// -----------------------------------------------------------------------------
module fq_ram
    import fetch_queue_pkg::*;
#(
    parameter int BUS_WD  = FS_TO_DS_BUS_WD,
    parameter int DEPTH   = FQ_DEPTH_DEF,
    parameter int ADDR_WD = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_WD-1:0] waddr,
    input  logic [BUS_WD-1:0]  wdata,
    input  logic [ADDR_WD-1:0] raddr,
    output logic [BUS_WD-1:0]  rdata
);

    logic [BUS_WD-1:0] mem [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the occupancy
    // counter, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fq_ram

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// DEPTH-entry circular FIFO between IF and ID, replacing the single fs_to_ds
// register slot so IF can keep fetching while ID stalls. Both sides use the
// valid/allowin handshake; br_flush drops all wrong-path entries.
//
// Optional feature (macro FQ_BYPASS_EN): when the queue is empty an incoming
// entry is presented to ID in the same cycle, and is not stored if ID takes it.
// Without the macro the minimum latency is one cycle and all outputs depend
// only on registered state.
//
// Ports:
//   clk            : clock, rising edge
//   reset          : synchronous, active-high reset
//   fs_to_fq_valid : IF presents a valid entry
//   fs_to_fq_bus   : entry from IF
//   fq_allowin     : queue accepts an entry this cycle (registered-state only)
//   fq_to_ds_valid : head entry valid for ID
//   fq_to_ds_bus   : head entry
//   ds_allowin     : ID accepts the head entry this cycle
//   br_flush       : discard all entries (branch redirect)
//   fq_count       : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int BUS_WD = FS_TO_DS_BUS_WD,
    parameter int DEPTH  = FQ_DEPTH_DEF,
    parameter int CNT_WD = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fs_to_fq_valid,
    input  logic [BUS_WD-1:0] fs_to_fq_bus,
    output logic              fq_allowin,
    output logic              fq_to_ds_valid,
    output logic [BUS_WD-1:0] fq_to_ds_bus,
    input  logic              ds_allowin,
    input  logic              br_flush,
    output logic [CNT_WD-1:0] fq_count
);

    localparam int                PTR_WD   = $clog2(DEPTH);
    localparam logic [CNT_WD-1:0] FULL_CNT = CNT_WD'(DEPTH);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of two, at least 2");
    end

    logic [PTR_WD-1:0] rd_ptr;
    logic [PTR_WD-1:0] wr_ptr;
    logic [CNT_WD-1:0] count;
    logic [BUS_WD-1:0] head_bus;
    logic              push;
    logic              pop;
    logic              byp_take;

    // Full queue refuses entry even if ID pops this cycle: keeps allowin off
    // the combinational path from ds_allowin.
    assign fq_allowin = (count != FULL_CNT);
    assign fq_count   = count;

`ifdef FQ_BYPASS_EN
    logic byp_active;

    assign byp_active     = (count == '0) && fs_to_fq_valid && !br_flush;
    assign byp_take       = byp_active && ds_allowin;
    assign fq_to_ds_valid = (count != '0) || byp_active;
    assign fq_to_ds_bus   = byp_active ? fs_to_fq_bus : head_bus;
`else
    assign byp_take       = 1'b0;
    assign fq_to_ds_valid = (count != '0);
    assign fq_to_ds_bus   = head_bus;
`endif

    // A bypassed entry consumed directly by ID is never written.
    assign push = fs_to_fq_valid && fq_allowin && !byp_take;
    // Only stored entries are popped; an empty queue ignores ds_allowin.
    assign pop  = (count != '0) && ds_allowin;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (br_flush) begin
            // Flush overrides any same-cycle push or pop.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WD'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WD'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_WD'(1);
            end else if (pop && !push) begin
                count <= count - CNT_WD'(1);
            end
        end
    end

    fq_ram #(
        .BUS_WD (BUS_WD),
        .DEPTH  (DEPTH),
        .ADDR_WD(PTR_WD)
    ) u_ram (
        .clk  (clk),
        .we   (push && !br_flush),
        .waddr(wr_ptr),
        .wdata(fs_to_fq_bus),
        .raddr(rd_ptr),
        .rdata(head_bus)
    );

endmodule : fetch_queue
